// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the decode-stage hazard logic and its companion decoder.
// Holds the stage/forwarding data formats, the in-flight entry array, the
// control word produced by controller_unit, and the default watchdog bound.
package pipeline_pkg;

  localparam int NUM_STAGES          = 3;
  localparam int DATA_W              = 32;
  localparam int PC_W                = 32;
  localparam int STALL_LIMIT_DEFAULT = 15;

  typedef logic [DATA_W-1:0] int_t;
  typedef logic [4:0]        register_id_t;
  typedef logic [1:0]        stall_count_t;
  typedef logic [1:0]        forward_src_t;
  typedef logic [$clog2(NUM_STAGES)-1:0] stage_index_t;

  // One in-flight result: [0]=after decode, [1]=after execute, [2]=after memory.
  typedef struct packed {
    register_id_t registerId;
    logic         dataReady;
    int_t         data;
  } stage_register_data_t;

  typedef stage_register_data_t [NUM_STAGES-1:0] stages_register_data_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK
  } stage_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_PASS_B
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    use_rs1;
    logic    use_rs2;
    logic    alu_src_imm;
    alu_op_e alu_op;
  } control_signals_t;

  // Forwarding source code for a stage entry: 0 is reserved for the regfile.
  function automatic forward_src_t stage_to_source(stage_index_t idx);
    return forward_src_t'(idx) + forward_src_t'(1);
  endfunction

endpackage

// File: rtl/hazard_match_select.sv
// Priority selector over the in-flight stage entries.
// Lowest-index (nearest) non-skipped entry whose register id matches wins.
// Ports:
//   registerId - register being resolved
//   entries    - in-flight results, index 0 nearest to decode
//   skip       - per-entry mask; a set bit removes the entry from the search
//   hit        - some entry matched
//   index      - index of the winning entry (valid when hit)
//   ready      - winning entry has its data available
//   data       - winning entry data (zero when no hit)
module hazard_match_select
  import pipeline_pkg::*;
(
  input  register_id_t          registerId,
  input  stages_register_data_t entries,
  input  logic [NUM_STAGES-1:0] skip,
  output logic                  hit,
  output stage_index_t          index,
  output logic                  ready,
  output int_t                  data
);

  // Scan from the far end so the nearest match is the last assignment.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    ready = 1'b0;
    data  = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!skip[i] && (entries[i].registerId == registerId)) begin
        hit   = 1'b1;
        index = stage_index_t'(i);
        ready = entries[i].dataReady;
        data  = entries[i].data;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Per-operand RAW hazard resolver for the decode stage.
// Forwards the nearest ready in-flight result, or requests a stall when the
// nearest producer has not finished; also watches for a stall that never
// resolves on the same PC.
// Ports:
//   clock, reset        - rising-edge clock, async active-low reset
//   programCounter      - PC of the instruction in decode
//   registerId          - source register to resolve (0 is hardwired zero)
//   originalData        - register-file read value
//   stallCount          - cycles decode has already stalled; entries below it are stale
//   dataFromNextStages  - in-flight results, [0] nearest to decode
//   forwardedData       - resolved operand (combinational)
//   stall               - operand not yet available (combinational)
//   forwardedFrom       - 0 = regfile, n = stage entry n-1 (combinational)
//   deadlock            - registered watchdog flag
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int MAX_STALL = STALL_LIMIT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PC_W-1:0]       programCounter,
  input  register_id_t          registerId,
  input  int_t                  originalData,
  input  stall_count_t          stallCount,
  input  stages_register_data_t dataFromNextStages,
  output int_t                  forwardedData,
  output logic                  stall,
  output forward_src_t          forwardedFrom,
  output logic                  deadlock
);

  localparam int CNT_W = $clog2(MAX_STALL + 1);

  logic [NUM_STAGES-1:0] skip;
  logic                  sel_hit;
  stage_index_t          sel_index;
  logic                  sel_ready;
  int_t                  sel_data;

  logic [CNT_W-1:0] stall_cycles_d, stall_cycles_q;
  logic [PC_W-1:0]  last_pc_d, last_pc_q;
  logic             deadlock_d, deadlock_q;

  // While decode is stalled, the nearest stallCount entries belong to
  // instructions already behind us; x0 never has a producer.
  always_comb begin
    skip = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      skip[i] = (registerId == '0) || (i < int'(stallCount));
    end
  end

  hazard_match_select u_match_select (
    .registerId (registerId),
    .entries    (dataFromNextStages),
    .skip       (skip),
    .hit        (sel_hit),
    .index      (sel_index),
    .ready      (sel_ready),
    .data       (sel_data)
  );

  always_comb begin
    forwardedData = originalData;
    stall         = 1'b0;
    forwardedFrom = '0;
    if (sel_hit) begin
      forwardedFrom = stage_to_source(sel_index);
      if (sel_ready) begin
        forwardedData = sel_data;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = '0;
    last_pc_d      = programCounter;
    deadlock_d     = deadlock_q;
    if (stall && (programCounter == last_pc_q)) begin
      stall_cycles_d = (stall_cycles_q == '1) ? stall_cycles_q
                                              : stall_cycles_q + CNT_W'(1);
    end else if (stall) begin
      stall_cycles_d = CNT_W'(1);
    end
    if (!stall) begin
      deadlock_d = 1'b0;
    end else if (stall_cycles_d >= CNT_W'(MAX_STALL)) begin
      deadlock_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      last_pc_q      <= '0;
      deadlock_q     <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      last_pc_q      <= last_pc_d;
      deadlock_q     <= deadlock_d;
    end
  end

  assign deadlock = deadlock_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import pipeline_pkg::*;

  localparam int MAXS = 15;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [PC_W-1:0]       programCounter = '0;
  register_id_t          registerId = '0;
  int_t                  originalData = '0;
  stall_count_t          stallCount = '0;
  stages_register_data_t dataFromNextStages = '0;
  int_t                  forwardedData;
  logic                  stall;
  forward_src_t          forwardedFrom;
  logic                  deadlock;

  hazard_unit #(.MAX_STALL(MAXS)) dut (
    .clock              (clock),
    .reset              (reset),
    .programCounter     (programCounter),
    .registerId         (registerId),
    .originalData       (originalData),
    .stallCount         (stallCount),
    .dataFromNextStages (dataFromNextStages),
    .forwardedData      (forwardedData),
    .stall              (stall),
    .forwardedFrom      (forwardedFrom),
    .deadlock           (deadlock)
  );

  always #5 clock = ~clock;

  typedef struct {
    int_t       data;
    logic       stl;
    logic [1:0] from;
    logic       dl;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference state: plain integers, updated once per rising edge.
  int              m_run = 0;
  logic [PC_W-1:0] m_last_pc = '0;
  logic            m_dl = 1'b0;
  logic            m_cur_stall = 1'b0;

  function automatic stage_register_data_t mk(int id, bit rdy, int_t d);
    stage_register_data_t e;
    e.registerId = register_id_t'(id);
    e.dataReady  = rdy;
    e.data       = d;
    return e;
  endfunction

  // Operand resolution straight from the rules: skip stale entries,
  // nearest match wins, unready nearest match stalls.
  function automatic exp_t ref_comb(register_id_t rid, int_t orig, stall_count_t sc,
                                    stages_register_data_t ents);
    exp_t r;
    r.data = orig;
    r.stl  = 1'b0;
    r.from = 2'd0;
    r.dl   = 1'b0;
    if (rid == 0) return r;
    for (int i = int'(sc); i < NUM_STAGES; i++) begin
      if (ents[i].registerId == rid) begin
        r.from = 2'(i + 1);
        if (ents[i].dataReady) r.data = ents[i].data;
        else r.stl = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic drive(bit rst, logic [PC_W-1:0] pc, int rid, int_t orig, int sc,
                       stages_register_data_t ents);
    exp_t e;
    @(posedge clock);
    if (reset) begin
      if (m_cur_stall) m_run = (programCounter == m_last_pc) ? m_run + 1 : 1;
      else m_run = 0;
      if (!m_cur_stall) m_dl = 1'b0;
      else if (m_run >= MAXS) m_dl = 1'b1;
      m_last_pc = programCounter;
    end
    #1;
    reset              = rst;
    programCounter     = pc;
    registerId         = register_id_t'(rid);
    originalData       = orig;
    stallCount         = stall_count_t'(sc);
    dataFromNextStages = ents;
    if (!rst) begin
      m_run = 0;
      m_last_pc = '0;
      m_dl = 1'b0;
    end
    e = ref_comb(registerId, orig, stallCount, ents);
    m_cur_stall = e.stl;
    e.dl = m_dl;
    q.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_total++;
    if (act !== expv) $display("FAIL %s: got %0h expected %0h", name, act, expv);
    else n_pass++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("forwardedData", forwardedData, e.data);
        chk("stall", 32'(stall), 32'(e.stl));
        chk("forwardedFrom", 32'(forwardedFrom), 32'(e.from));
        chk("deadlock", 32'(deadlock), 32'(e.dl));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    stages_register_data_t ents;
    logic [PC_W-1:0] pc;
    int wait_cycles;

    ents = '0;
    ents[0] = mk(0, 1, 32'd5);
    drive(0, 32'h0, 0, 32'h77, 0, ents);
    drive(0, 32'h0, 8, 32'h77, 0, ents);
    drive(1, 32'h0, 0, 32'h77, 0, ents);

    ents = '0;
    ents[0] = mk(8, 1, 32'hAA);
    ents[1] = mk(8, 1, 32'hBB);
    drive(1, 32'h100, 8, 32'h11, 0, ents);

    ents[0] = mk(8, 0, 32'hDEAD);
    ents[1] = mk(9, 1, 32'hBB);
    drive(1, 32'h104, 8, 32'h22, 0, ents);

    ents[1] = mk(8, 1, 32'h42);
    drive(1, 32'h104, 8, 32'h22, 1, ents);

    ents = '0;
    ents[0] = mk(1, 1, 32'h1);
    ents[1] = mk(2, 0, 32'h2);
    ents[2] = mk(4, 1, 32'h3);
    drive(1, 32'h108, 3, 32'h1234, 0, ents);

    ents[2] = mk(3, 0, 32'h3);
    drive(1, 32'h10c, 3, 32'h55, 3, ents);
    drive(1, 32'h10c, 3, 32'h55, 2, ents);

    // Long stall on one PC, then release, then reset in the middle of a count.
    ents = '0;
    ents[0] = mk(8, 0, 32'h0);
    for (int i = 0; i < MAXS + 4; i++) drive(1, 32'h400010, 8, 32'h9, 0, ents);
    ents[0] = mk(8, 1, 32'hC0);
    drive(1, 32'h400010, 8, 32'h9, 0, ents);
    drive(1, 32'h400014, 8, 32'h9, 0, ents);
    ents[0] = mk(8, 0, 32'h0);
    for (int i = 0; i < MAXS + 2; i++) drive(1, 32'h400020, 8, 32'h9, 0, ents);
    drive(0, 32'h400020, 8, 32'h9, 0, ents);
    drive(0, 32'h400020, 8, 32'h9, 0, ents);
    for (int i = 0; i < MAXS + 1; i++) drive(1, 32'h400020, 8, 32'h9, 0, ents);
    // PC change while stalled restarts the count.
    for (int i = 0; i < 6; i++) drive(1, 32'h400030 + 32'(i[0]), 8, 32'h9, 0, ents);

    pc = 32'h200;
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < NUM_STAGES; i++)
        ents[i] = mk(($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 3),
                     $urandom_range(0, 2) != 0, $urandom);
      if ($urandom_range(0, 7) == 0) pc = $urandom_range(0, 3) * 4 + 32'h200;
      drive(($urandom_range(0, 199) != 0), pc,
            ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(0, 3),
            $urandom, $urandom_range(0, 3), ents);
    end

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
